// File: rtl/muldiv_pkg.sv
// Shared types and op decode helpers for the iterative RISC-V M-extension unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    CALC = 2'd2,
    FIX  = 2'd3
  } muldiv_state_e;

  function automatic logic is_div(muldiv_op_e op);
    return op[2];
  endfunction

  // MUL keeps only the low half, which is the same for any signedness.
  function automatic logic op_signed_a(muldiv_op_e op);
    return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
  endfunction

  function automatic logic op_signed_b(muldiv_op_e op);
    return (op == MULH) || (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational magnitude and sign extraction of both operands for the given op.
module muldiv_operand_prep
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  muldiv_op_e        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   absA,
  output logic [XLEN-1:0]   absB,
  output logic              negA,
  output logic              negB
);

  assign negA = op_signed_a(op) & a[XLEN-1];
  assign negB = op_signed_b(op) & b[XLEN-1];
  assign absA = negA ? -a : a;
  assign absB = negB ? -b : b;

endmodule

// File: rtl/rv_muldiv_seq.sv
// Iterative MUL/DIV unit: XLEN+3 cycles per op, start ignored while busy; kill aborts silently.
// MULDIV_FAST_ZERO_EN: zero operands skip the iteration phase (done 2 edges after accept).
module rv_muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int CNTW = $clog2(XLEN) + 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   result
);

  muldiv_state_e     state;
  muldiv_op_e        opR;
  logic [CNTW-1:0]   counter;
  logic [XLEN-1:0]   aR, bR, magA, magB;
  logic [2*XLEN-1:0] acc;
  logic              negS, negR;

  logic [XLEN-1:0]   absA, absB;
  logic              negA, negB;

  muldiv_operand_prep #(.XLEN(XLEN)) uPrep (
    .op   (opR),
    .a    (aR),
    .b    (bR),
    .absA (absA),
    .absB (absB),
    .negA (negA),
    .negB (negB)
  );

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV.
  logic [XLEN-1:0]   mulAdd, quotFix, remFix, fixVal;
  logic [XLEN:0]     mulSum, remShift, divDiff;
  logic [2*XLEN-1:0] prodFix;
  logic              bZero;

  always_comb begin
    mulAdd   = acc[0] ? magA : '0;
    mulSum   = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, mulAdd};
    remShift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    divDiff  = remShift - {1'b0, magB};
    prodFix  = negS ? -acc : acc;
    quotFix  = negS ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    remFix   = negR ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    bZero    = (bR == '0);
    case (opR)
      MUL:                 fixVal = prodFix[XLEN-1:0];
      MULH, MULHSU, MULHU: fixVal = prodFix[2*XLEN-1:XLEN];
      DIV, DIVU:           fixVal = bZero ? '1 : quotFix;
      default:             fixVal = bZero ? aR : remFix;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      opR     <= MUL;
      counter <= '0;
      aR      <= '0;
      bR      <= '0;
      magA    <= '0;
      magB    <= '0;
      acc     <= '0;
      negS    <= 1'b0;
      negR    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              opR   <= muldiv_op_e'(op);
              aR    <= a;
              bR    <= b;
              busy  <= 1'b1;
              state <= PREP;
            end
          end
          PREP: begin
            magA    <= absA;
            magB    <= absB;
            negS    <= negA ^ negB;
            negR    <= negA;
            acc     <= {{XLEN{1'b0}}, (is_div(opR) ? absA : absB)};
            counter <= CNTW'(XLEN - 1);
            state   <= CALC;
`ifdef MULDIV_FAST_ZERO_EN
            if ((aR == '0) || (bR == '0)) begin
              acc   <= '0;
              state <= FIX;
            end
`endif
          end
          CALC: begin
            if (is_div(opR))
              acc <= divDiff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                   : {divDiff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
              acc <= {mulSum, acc[XLEN-1:1]};
            counter <= counter - CNTW'(1);
            if (counter == '0) state <= FIX;
          end
          FIX: begin
            result <= fixVal;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rv_muldiv_seq.sv
// Directed bench for rv_muldiv_seq at XLEN=64 and XLEN=32 (honours MULDIV_FAST_ZERO_EN).
module tb_rv_muldiv_seq;

`ifdef MULDIV_FAST_ZERO_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        Clk, Reset, kill;
  logic        start64, start32;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic        busy64, done64, busy32, done32;
  logic [63:0] res64;
  logic [31:0] res32;

  int checks = 0;
  int failures = 0;

  rv_muldiv_seq #(.XLEN(64)) dut64 (
    .Clk(Clk), .Reset(Reset), .start(start64), .op(op), .a(a), .b(b),
    .kill(kill), .busy(busy64), .done(done64), .result(res64)
  );

  rv_muldiv_seq #(.XLEN(32)) dut32 (
    .Clk(Clk), .Reset(Reset), .start(start32), .op(op), .a(a[31:0]), .b(b[31:0]),
    .kill(kill), .busy(busy32), .done(done32), .result(res32)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, got, exp);
    end
  endtask

  // Edges after the accept edge until done is seen: XLEN+2 normally, 2 on the zero fast path.
  function automatic int expLat(input bit w32, input logic [63:0] x, input logic [63:0] y);
    logic zero;
    zero = w32 ? ((x[31:0] == 32'd0) || (y[31:0] == 32'd0)) : ((x == 64'd0) || (y == 64'd0));
    if (FAST && zero) return 2;
    return w32 ? 34 : 66;
  endfunction

  task automatic waitDone(input bit w32, output int d, output logic [63:0] r);
    d = -1;
    r = '0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge Clk); #1;
      if (w32 ? done32 : done64) begin
        d = i;
        r = w32 ? {32'd0, res32} : res64;
        break;
      end
    end
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the done edge.
  task automatic runOp(input bit w32, input logic [2:0] o, input logic [63:0] x,
                       input logic [63:0] y, output logic [63:0] r, output int d);
    op = o; a = x; b = y;
    if (w32) start32 = 1'b1; else start64 = 1'b1;
    @(posedge Clk); #1;
    start32 = 1'b0;
    start64 = 1'b0;
    waitDone(w32, d, r);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] M5   = 64'hFFFF_FFFF_FFFF_FFFB;
  localparam logic [63:0] M7   = 64'hFFFF_FFFF_FFFF_FFF9;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  vec_t        vecs[21];
  logic [63:0] r;
  int          d, nDone;

  initial begin
    vecs[0]  = '{3'b000, 64'd3, M5, 64'hFFFF_FFFF_FFFF_FFF1};
    vecs[1]  = '{3'b001, 64'd3, M5, ONES};
    vecs[2]  = '{3'b011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE};
    vecs[3]  = '{3'b010, ONES, 64'd2, ONES};
    vecs[4]  = '{3'b010, 64'd2, ONES, 64'd1};
    vecs[5]  = '{3'b100, M7, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD};
    vecs[6]  = '{3'b110, M7, 64'd2, ONES};
    vecs[7]  = '{3'b101, 64'd7, 64'd2, 64'd3};
    vecs[8]  = '{3'b111, 64'd7, 64'd2, 64'd1};
    vecs[9]  = '{3'b100, M7, 64'd0, ONES};
    vecs[10] = '{3'b111, 64'h1234, 64'd0, 64'h1234};
    vecs[11] = '{3'b110, M7, 64'd0, M7};
    vecs[12] = '{3'b100, MIN, ONES, MIN};
    vecs[13] = '{3'b110, MIN, ONES, 64'd0};
    vecs[14] = '{3'b000, 64'd0, 64'd5, 64'd0};
    vecs[15] = '{3'b101, 64'd0, 64'd3, 64'd0};
    vecs[16] = '{3'b101, 64'd0, 64'd0, ONES};
    vecs[17] = '{3'b000, 64'h1_0000_0001, 64'h1_0000_0001, 64'h2_0000_0001};
    vecs[18] = '{3'b011, 64'h1_0000_0001, 64'h1_0000_0001, 64'd1};
    vecs[19] = '{3'b101, ONES, 64'h1_0000_0000, 64'hFFFF_FFFF};
    vecs[20] = '{3'b111, ONES, 64'h1_0000_0000, 64'hFFFF_FFFF};

    Reset = 1'b1; kill = 1'b0; start64 = 1'b0; start32 = 1'b0;
    op = 3'b000; a = '0; b = '0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    check("rst_busy64", {63'd0, busy64}, 64'd0);
    check("rst_done64", {63'd0, done64}, 64'd0);
    check("rst_res64", res64, 64'd0);
    check("rst_busy32", {63'd0, busy32}, 64'd0);
    check("rst_res32", {32'd0, res32}, 64'd0);

    // Each vector starts in the done cycle of the previous one.
    for (int i = 0; i < 21; i++) begin
      runOp(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, r, d);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 64'(d), 64'(expLat(1'b0, vecs[i].a, vecs[i].b)));
    end

    // start pulse while busy, with different operands, is dropped
    op = 3'b000; a = 64'd6; b = 64'd7; start64 = 1'b1;
    @(posedge Clk); #1 start64 = 1'b0;
    repeat (5) @(posedge Clk);
    #1 check("busy_in_flight", {63'd0, busy64}, 64'd1);
    a = 64'd100; start64 = 1'b1;
    @(posedge Clk); #1 start64 = 1'b0;
    nDone = 0; r = '0;
    for (int i = 0; i < 150; i++) begin
      @(posedge Clk); #1;
      if (done64) begin nDone++; r = res64; end
    end
    check("busy_start_done_count", 64'(nDone), 64'd1);
    check("busy_start_result", r, 64'd42);

    // operands changed mid-operation have no effect
    op = 3'b101; a = 64'd1000; b = 64'd10; start64 = 1'b1;
    @(posedge Clk); #1 start64 = 1'b0;
    repeat (3) @(posedge Clk);
    #1 op = 3'b000; a = 64'd5; b = 64'd1;
    waitDone(1'b0, d, r);
    check("midop_change_result", r, 64'd100);

    // explicit back-to-back: second start issued in the first done cycle
    runOp(1'b0, 3'b000, 64'd6, 64'd7, r, d);
    check("b2b_first", r, 64'd42);
    runOp(1'b0, 3'b101, 64'd50, 64'd5, r, d);
    check("b2b_second", r, 64'd10);
    check("b2b_latency", 64'(d), 64'd66);

    // kill in CALC cycle 10
    op = 3'b101; a = 64'd100; b = 64'd7; start64 = 1'b1;
    @(posedge Clk); #1 start64 = 1'b0;
    repeat (10) @(posedge Clk);
    #1 check("kill_pre_busy", {63'd0, busy64}, 64'd1);
    kill = 1'b1;
    @(posedge Clk); #1 kill = 1'b0;
    check("kill_busy", {63'd0, busy64}, 64'd0);
    nDone = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge Clk); #1;
      if (done64) nDone++;
    end
    check("kill_no_done", 64'(nDone), 64'd0);
    check("kill_result_kept", res64, 64'd10);

    // kill together with start while idle
    start64 = 1'b1; kill = 1'b1;
    @(posedge Clk); #1 start64 = 1'b0; kill = 1'b0;
    check("kill_start_idle", {63'd0, busy64}, 64'd0);

    // asynchronous reset mid-CALC
    op = 3'b101; a = 64'd1000; b = 64'd3; start64 = 1'b1;
    @(posedge Clk); #1 start64 = 1'b0;
    repeat (20) @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy64}, 64'd0);
    check("arst_done", {63'd0, done64}, 64'd0);
    check("arst_result", res64, 64'd0);
    @(posedge Clk); #1 Reset = 1'b0;

    runOp(1'b0, 3'b000, 64'd6, 64'd7, r, d);
    check("post_reset_mul", r, 64'd42);

    // XLEN=32 instance
    runOp(1'b1, 3'b000, 64'd3, 64'hFFFF_FFFB, r, d);
    check("x32_mul", r, 64'hFFFF_FFF1);
    check("x32_latency", 64'(d), 64'd34);
    runOp(1'b1, 3'b001, 64'd3, 64'hFFFF_FFFB, r, d);
    check("x32_mulh", r, 64'hFFFF_FFFF);
    runOp(1'b1, 3'b100, 64'hFFFF_FFF9, 64'd2, r, d);
    check("x32_div", r, 64'hFFFF_FFFD);
    runOp(1'b1, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, r, d);
    check("x32_rem_ovf", r, 64'd0);
    runOp(1'b1, 3'b100, 64'd9, 64'd0, r, d);
    check("x32_div0", r, 64'hFFFF_FFFF);
    check("x32_div0_latency", 64'(d), 64'(expLat(1'b1, 64'd9, 64'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_muldiv_seq.md
Name: rv_muldiv_seq

Overview:
- Parametrised iterative multiply/divide unit implementing the RISC-V M-extension integer operations for the multicycle core.
- Sits beside Ula64 in the datapath. Operands come from A/B, the op comes from instruction funct3, and the result goes to the register-file write mux.
- The control unit stalls on busy and writes back when done pulses.
- Width is generic so the same block serves RV32 and RV64 builds.

Parameters:
- XLEN, 64, operand/result width in bits; legal values 32 and 64.
- CNTW, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand; captured on accept.
- b  input  XLEN  rs2 operand; captured on accept.
- kill  input  1  abandon the current operation (trap/flush).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse; result valid in that cycle.
- result  output  XLEN  registered result; held until the next accept.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, counter=0, all internal registers 0.
- States:
  - IDLE: start=1 → PREP.
  - PREP: 1 cycle; take absolute values per op signedness and record result sign → CALC.
  - CALC: exactly XLEN cycles, counter XLEN-1 down to 0; 1 bit per cycle.
    - Multiply: shift-add over a 2*XLEN product register.
    - Divide: restoring division with XLEN-bit remainder.
    - At counter=0 → FIX.
  - FIX: 1 cycle; negate if required, select low/high half or quotient/remainder, register result, assert done → IDLE.
- Latency: start accepted at edge k; done=1 during the cycle after edge k+XLEN+2 (XLEN+3 cycles total). busy=1 from after edge k until the edge that enters IDLE; busy=0 in the done cycle.
- Operand capture: a, b and op are registered at accept. Later input changes have no effect.
- start while busy: ignored, never queued.
- start in the done cycle: accepted, giving back-to-back operation with no dead cycle.
- kill:
  - Synchronous. Any non-IDLE state → IDLE next edge, with no done and result unchanged.
  - kill together with start while IDLE: start is ignored.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: signed.
  - Remainder sign follows the dividend.
- MUL returns low XLEN bits; MULH* return high XLEN bits of the 2*XLEN product.
- Divide by zero (b=0): DIV/DIVU return all ones; REM/REMU return a. Full latency still applies.
- Signed overflow (a=most-negative, b=-1): DIV returns a; REM returns 0.
- Intermediates are full width; no truncation before FIX.

Optional Feature:
- Macro MULDIV_FAST_ZERO_EN.
- When defined: in PREP, if b=0 (any op) or a=0 (any op), skip CALC and go straight to FIX with the architected result. done then arrives 2 cycles after accept (after edge k+2).
- When undefined: every operation takes the full XLEN+3 cycles. Results are identical in both builds; only latency differs.

Decomposition:
- Package muldiv_pkg:
  - muldiv_op_e enum (the 8 funct3 codes).
  - muldiv_state_e enum (IDLE, PREP, CALC, FIX).
  - Helper functions is_div(op), op_signed_a(op), op_signed_b(op).
- Sub-module muldiv_operand_prep: combinational absolute value and sign flags for a/b given op, parametrised by XLEN.
- FSM and datapath stay in rv_muldiv_seq.

Test Plan:
1. XLEN=64, MUL, a=3, b=-5 (0xFFFF_FFFF_FFFF_FFFB) → done after exactly 67 cycles, result=0xFFFF_FFFF_FFFF_FFF1; MULH of the same operands → 0xFFFF_FFFF_FFFF_FFFF.
2. MULHU, a=b=0xFFFF_FFFF_FFFF_FFFF → result 0xFFFF_FFFF_FFFF_FFFE; MULHSU, a=-1, b=2 → result 0xFFFF_FFFF_FFFF_FFFF.
3. DIV, a=-7, b=2 → -3; REM of the same operands → -1; DIVU, a=7, b=2 → 3; REMU of the same → 1.
4. b=0: DIV → all ones, REMU a=0x1234 → 0x1234. Overflow: DIV a=0x8000_0000_0000_0000, b=-1 → 0x8000_0000_0000_0000; REM → 0. Repeat with MULDIV_FAST_ZERO_EN defined: b=0 cases done after 2 cycles.
5. Handshake:
   - Pulse start while busy: ignored, exactly one done.
   - Start in the done cycle: second result arrives XLEN+3 cycles later.
   - Change a/b mid-operation: result unaffected.
6. Abort:
   - Assert kill in CALC cycle 10: no done, busy=0 next cycle, result keeps its prior value.
   - Assert Reset asynchronously mid-CALC: busy/done/result go to 0 immediately, before the next clock edge.
   - Repeat at XLEN=32 with test 1 operands: 35-cycle latency, MUL result 0xFFFF_FFF1.
